spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
SPI target (slave) engine, the far end of the SPI controller/datapath link; lets the MCU act as an SPI peripheral to an external master.
- Oversamples the external SCLK, CS_N and MOSI in the system clock domain.
- Supports CPOL/CPHA modes 0-3 and MSB/LSB-first.
- Exchanges 8-bit frames through single-entry TX and RX holding registers with valid/ready handshakes toward the register block.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK/CS_N/MOSI (min 2).
- DATA_W, 8, frame width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_clk_i  in  1  SCLK from external master
- spi_cs_i  in  1  chip select, active low
- spi_mosi_i  in  1  master-out data
- spi_miso_o  out  1  slave-out data
- spi_miso_oe_o  out  1  MISO output enable (pad tri-state control)
- cfg_cpol_i  in  1  SCLK idle level
- cfg_cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_lsb_first_i  in  1  bit order
- tx_data_i  in  DATA_W  next word to transmit
- tx_valid_i  in  1  tx write strobe
- tx_ready_o  out  1  TX holding register empty
- rx_data_o  out  DATA_W  received word
- rx_valid_o  out  1  RX holding register full
- rx_ready_i  in  1  RX consume strobe
- busy_o  out  1  CS asserted (synchronized)
- tx_underrun_o  out  1  one-cycle pulse: word loaded while TX empty
- rx_overrun_o  out  1  one-cycle pulse: byte completed while RX full
- frame_err_o  out  1  one-cycle pulse: CS deasserted mid-frame

Behaviour:
- Reset: all outputs 0, except tx_ready_o=1. State IDLE; shift registers, bit counter and holding registers cleared.
- Requirement: f_clk >= 8x f_sclk.
- Input path: each input passes through SYNC_STAGES flops plus one edge-detect flop. MISO updates SYNC_STAGES+1 clk after the causing SCLK or CS edge.
- Edge definitions: leading edge = SCLK leaving the cfg_cpol_i level; trailing edge = SCLK returning to it. cfg_* are sampled only in IDLE and held constant for the whole CS assertion.
- State IDLE -> ACTIVE on synchronized CS fall. ACTIVE -> IDLE on CS rise.
- Entry to ACTIVE:
  - busy_o=1, spi_miso_oe_o=1, bit counter=0.
  - If CPHA=0, load a word (see Load) and drive its first bit immediately.
- Load:
  - If TX is full: take tx_data, set tx_ready_o=1.
  - If TX is empty: take 8'hFF and pulse tx_underrun_o.
  - First bit out is bit 7 (MSB-first) or bit 0 (LSB-first).
- CPHA=0: sample MOSI on leading edge; drive next bit on trailing edge.
- CPHA=1: drive on leading edge (first leading edge of a frame performs Load); sample on trailing edge.
- Frame completion: on the 8th sample, the assembled word is offered to RX.
  - RX empty, or rx_ready_i high the same cycle: write, rx_valid_o=1.
  - Otherwise: keep old data, drop new word, pulse rx_overrun_o.
  - Then bit counter=0. If CPHA=0, perform Load; the next trailing edge drives the new word's first bit. Back-to-back frames continue while CS stays low.
- TX write: accepted only when tx_ready_o=1 in that cycle. A write while full is ignored.
  - Load and write in the same cycle with TX full: load takes the old word; the write is ignored because ready was 0.
  - Load and write in the same cycle with TX empty: the load underruns; the write is accepted.
- RX read: rx_ready_i with rx_valid_o=1 clears rx_valid_o next cycle; rx_data_o stays held.
- CS rise with bit counter != 0: partial word discarded, pulse frame_err_o. A word already loaded for transmit counts as consumed.
- CS rise, any case: spi_miso_oe_o=0, spi_miso_o=0, busy_o=0.
- SCLK edges while CS is high are ignored.
- Asynchronous reset mid-frame: immediate return to the reset state; no pulses generated.

Decomposition:
- spi_defs package:
  - type_spi_slave_state_e (IDLE, ACTIVE)
  - SPI_SLV_SYNC_STAGES constant
  - SPI_SLV_DATA_W constant
- Sub-module spi_slave_sync: synchronizer chain plus rise/fall detect. Instantiate once each for SCLK, CS_N and MOSI (MOSI uses level output only).

Test Plan:
- Mode 0, MSB-first: preload tx 0xA5; master sends 0x3C -> rx_data_o=0x3C, rx_valid_o=1; master captures 0xA5; tx_ready_o=1.
- Mode 3, LSB-first: tx 0x81; master sends 0x12 -> rx 0x12; master captures 0x81.
- CS held, two frames: tx 0x11 then 0x22 written during frame 1; master sends 0xAA,0x55 -> master gets 0x11,0x22; rx drained between frames gives 0xAA,0x55.
- Underrun and overrun: no tx data, rx never read, two frames 0x01,0x02 -> master gets 0xFF,0xFF; tx_underrun_o pulses twice; rx_data_o=0x01; rx_overrun_o one pulse.
- CS rises after 5 SCLK cycles -> frame_err_o pulse, rx_valid_o stays 0, spi_miso_oe_o=0.
- rst_n asserted mid-frame -> all outputs at reset values within the same cycle; the next full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_defs.sv
// Shared types and default sizing for the SPI target engine.
package spi_defs;

  localparam int SPI_SLV_SYNC_STAGES = 2;
  localparam int SPI_SLV_DATA_W      = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } type_spi_slave_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings one asynchronous pad signal into the clk domain and flags its edges.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // The reset value matches the line's idle level so no edge appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversampled SCLK/CS_N/MOSI, modes 0-3, MSB/LSB-first,
// single-entry TX/RX holding registers with valid/ready handshakes.
module spi_slave_core
  import spi_defs::*;
#(
  parameter int SYNC_STAGES = SPI_SLV_SYNC_STAGES,
  parameter int DATA_W      = SPI_SLV_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic              cfg_cpol_i,
  input  logic              cfg_cpha_i,
  input  logic              cfg_lsb_first_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              tx_underrun_o,
  output logic              rx_overrun_o,
  output logic              frame_err_o
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level_unused, cs_rise, cs_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_clk_i),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_i),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi_i),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  type_spi_slave_state_e state;
  logic              cpol, cpha, lsb_first;
  logic [DATA_W-1:0] tx_shift, rx_shift, tx_hold, rx_data;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_full, rx_valid;
  logic              miso, miso_oe, busy, underrun, overrun, frame_err;

  logic              lead_edge, trail_edge, sample_edge, drive_edge, load_now;
  logic [DATA_W-1:0] rx_word, load_word, tx_next;

  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge : trail_edge;
  assign rx_word     = lsb_first ? {mosi, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], mosi};
  assign load_word   = tx_full ? tx_hold : '1;
  assign tx_next     = lsb_first ? (tx_shift >> 1) : (tx_shift << 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // A word leaves the TX holding register at CS entry (CPHA=0), at the first
  // leading edge of a frame (CPHA=1), or right after the last sample (CPHA=0).
  always_comb begin
    load_now = 1'b0;  // NOTE: default assignment first so no latch is inferred
    if (state == IDLE) begin
      load_now = cs_fall && !cfg_cpha_i;
    end else if (!cs_rise) begin
      load_now = lead_edge && (cpha ? (bit_cnt == '0) : (bit_cnt == LAST_BIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: holding and shift registers are reset too, so rx_data_o reads 0 after reset
      state     <= IDLE;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      lsb_first <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      tx_hold   <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      tx_full   <= 1'b0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block take priority
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (load_now) begin
        if (tx_full) tx_full  <= 1'b0;
        else         underrun <= 1'b1;
      end
      if (tx_valid_i && !tx_full) begin
        tx_hold <= tx_data_i;
        tx_full <= 1'b1;
      end
      if (rx_ready_i && rx_valid) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cpol      <= cfg_cpol_i;
          cpha      <= cfg_cpha_i;
          lsb_first <= cfg_lsb_first_i;
          if (cs_fall) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
            bit_cnt <= '0;
            if (!cfg_cpha_i) begin
              tx_shift <= load_word;
              miso     <= first_bit(load_word, cfg_lsb_first_i);
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_word;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (!rx_valid || rx_ready_i) begin
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
                if (!cpha) tx_shift <= load_word;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            // With bit_cnt at zero the drive edge starts a fresh word rather than shifting.
            if (drive_edge) begin
              if (bit_cnt == '0) begin
                if (cpha) begin
                  tx_shift <= load_word;
                  miso     <= first_bit(load_word, lsb_first);
                end else begin
                  miso <= first_bit(tx_shift, lsb_first);
                end
              end else begin
                tx_shift <= tx_next;
                miso     <= first_bit(tx_next, lsb_first);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso_o    = miso;
  assign spi_miso_oe_o = miso_oe;
  assign tx_ready_o    = ~tx_full;
  assign rx_data_o     = rx_data;
  assign rx_valid_o    = rx_valid;
  assign busy_o        = busy;
  assign tx_underrun_o = underrun;
  assign rx_overrun_o  = overrun;
  assign frame_err_o   = frame_err;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master plus pulse counters.
module tb_spi_slave_core;

  localparam int HALF = 80;  // half SCLK period in ns (clk period is 10 ns)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0;
  logic       busy, tx_underrun, rx_overrun, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int n_underrun = 0, n_overrun = 0, n_frame_err = 0;
  int base_u, base_o, base_f;
  logic [7:0] got;

  spi_slave_core dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk_i(spi_clk), .spi_cs_i(spi_cs), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe),
    .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_lsb_first_i(cfg_lsb_first),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .busy_o(busy), .tx_underrun_o(tx_underrun), .rx_overrun_o(rx_overrun),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  // Each count is the number of clk cycles the pulse was seen high.
  always @(negedge clk) begin
    if (tx_underrun) n_underrun++;
    if (rx_overrun)  n_overrun++;
    if (frame_err)   n_frame_err++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    spi_clk = cpol;
  endtask

  task automatic cs_begin();
    #(HALF); spi_cs = 1'b0; #(HALF);
  endtask

  task automatic cs_end();
    #(HALF); spi_cs = 1'b1; #(2 * HALF);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic rx_drain();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  // Master side: CPHA=0 samples on leading edge, CPHA=1 on trailing edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    int b;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      b = cfg_lsb_first ? i : 7 - i;
      if (!cfg_cpha) begin
        spi_mosi = tx[b]; #(HALF);
        spi_clk = ~cfg_cpol; rx[b] = spi_miso; #(HALF);
        spi_clk = cfg_cpol;
      end else begin
        spi_clk = ~cfg_cpol; spi_mosi = tx[b]; #(HALF);
        spi_clk = cfg_cpol; rx[b] = spi_miso; #(HALF);
      end
    end
  endtask

  initial begin
    #100; rst_n = 1'b1; #20;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_miso", spi_miso, 0);

    // Mode 0, MSB-first
    set_mode(1'b0, 1'b0, 1'b0);
    tx_write(8'hA5);
    check("m0_tx_full", tx_ready, 0);
    cs_begin();
    check("m0_busy", busy, 1);
    check("m0_oe", spi_miso_oe, 1);
    check("m0_loaded", tx_ready, 1);
    xfer(8'h3C, 8, got);
    check("m0_master_rx", got, 8'hA5);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_rx_valid", rx_valid, 1);
    cs_end();
    check("m0_busy_end", busy, 0);
    check("m0_oe_end", spi_miso_oe, 0);
    rx_drain();
    check("m0_rx_cleared", rx_valid, 0);
    check("m0_rx_held", rx_data, 8'h3C);

    // Mode 3, LSB-first; the word is only taken at the first leading edge
    set_mode(1'b1, 1'b1, 1'b1);
    tx_write(8'h81);
    cs_begin();
    check("m3_not_loaded", tx_ready, 0);
    xfer(8'h12, 8, got);
    check("m3_master_rx", got, 8'h81);
    check("m3_rx_data", rx_data, 8'h12);
    check("m3_tx_ready", tx_ready, 1);
    cs_end();
    rx_drain();

    // Two frames under one CS; a write while full is dropped
    set_mode(1'b0, 1'b0, 1'b0);
    tx_write(8'h11);
    cs_begin();
    tx_write(8'h22);
    check("b2b_full", tx_ready, 0);
    tx_write(8'h99);
    xfer(8'hAA, 8, got);
    check("b2b_master_rx1", got, 8'h11);
    check("b2b_rx1", rx_data, 8'hAA);
    rx_drain();
    xfer(8'h55, 8, got);
    check("b2b_master_rx2", got, 8'h22);
    check("b2b_rx2", rx_data, 8'h55);
    cs_end();
    rx_drain();

    // Mode 1: empty TX and RX never read
    set_mode(1'b0, 1'b1, 1'b0);
    base_u = n_underrun; base_o = n_overrun;
    cs_begin();
    xfer(8'h01, 8, got);
    check("ur_master_rx1", got, 8'hFF);
    xfer(8'h02, 8, got);
    check("ur_master_rx2", got, 8'hFF);
    cs_end();
    check("ur_rx_data", rx_data, 8'h01);
    check("ur_rx_valid", rx_valid, 1);
    check("ur_underruns", n_underrun - base_u, 2);
    check("ur_overruns", n_overrun - base_o, 1);
    rx_drain();

    // CS rises after 5 SCLK cycles
    set_mode(1'b0, 1'b0, 1'b0);
    base_f = n_frame_err;
    cs_begin();
    xfer(8'hF0, 5, got);
    cs_end();
    check("fe_pulse", n_frame_err - base_f, 1);
    check("fe_rx_valid", rx_valid, 0);
    check("fe_rx_data", rx_data, 8'h01);
    check("fe_oe", spi_miso_oe, 0);
    check("fe_busy", busy, 0);

    // Reset in the middle of a frame, then a clean frame
    base_f = n_frame_err; base_o = n_overrun;
    tx_write(8'h77);
    cs_begin();
    xfer(8'hC3, 3, got);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_oe", spi_miso_oe, 0);
    check("mr_miso", spi_miso, 0);
    check("mr_tx_ready", tx_ready, 1);
    check("mr_rx_data", rx_data, 8'h00);
    check("mr_pulses", {tx_underrun, rx_overrun, frame_err}, 3'b000);
    #9; spi_cs = 1'b1; spi_clk = 1'b0;
    #40; rst_n = 1'b1; #40;
    cs_begin();
    xfer(8'h5A, 8, got);
    check("mr_master_rx", got, 8'hFF);
    check("mr_rx_data_new", rx_data, 8'h5A);
    check("mr_rx_valid_new", rx_valid, 1);
    cs_end();
    check("mr_no_frame_err", n_frame_err - base_f, 0);
    check("mr_no_overrun", n_overrun - base_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
